// File: rtl/condicionador_entradas.sv
// Input conditioning for the gate controller: per-channel two-flop synchronizer,
// debounce counter and registered one-cycle edge pulses, plus a sticky settling flag.
module condicionador_entradas #(
    parameter int N_CANAIS        = 4,
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_CANAIS-1:0] bruto,
    output logic [N_CANAIS-1:0] estavel,
    output logic [N_CANAIS-1:0] subida,
    output logic [N_CANAIS-1:0] descida,
    output logic                valido
);

    localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam int SW = $clog2(DEBOUNCE_CICLOS + 2);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(DEBOUNCE_CICLOS + 1);

    logic [N_CANAIS-1:0]         s1_q, s1_d;
    logic [N_CANAIS-1:0]         s2_q, s2_d;
    logic [N_CANAIS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_CANAIS-1:0]         estavel_q, estavel_d;
    logic [N_CANAIS-1:0]         subida_q, subida_d;
    logic [N_CANAIS-1:0]         descida_q, descida_d;
    logic [SW-1:0]               settle_q, settle_d;
    logic                        valido_q, valido_d;

    // Next-state: synchronizer shift, per-channel debounce qualification, settling count
    always_comb begin
        s1_d      = bruto;
        s2_d      = s1_q;
        cnt_d     = cnt_q;
        estavel_d = estavel_q;
        subida_d  = {N_CANAIS{1'b0}};
        descida_d = {N_CANAIS{1'b0}};
        for (int i = 0; i < N_CANAIS; i++) begin
            if (s2_q[i] == estavel_q[i]) begin
                // Any agreement discards a partial count, so glitches never accumulate
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]     = {CW{1'b0}};
                estavel_d[i] = s2_q[i];
                subida_d[i]  = s2_q[i];
                descida_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end

        if (valido_q) begin
            settle_d = settle_q;
            valido_d = 1'b1;
        end else begin
            settle_d = settle_q + SW'(1);
            valido_d = (settle_q == SETTLE_MAX);
        end
    end

    // State registers, all cleared asynchronously by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q      <= {N_CANAIS{1'b0}};
            s2_q      <= {N_CANAIS{1'b0}};
            cnt_q     <= '0;
            estavel_q <= {N_CANAIS{1'b0}};
            subida_q  <= {N_CANAIS{1'b0}};
            descida_q <= {N_CANAIS{1'b0}};
            settle_q  <= {SW{1'b0}};
            valido_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            estavel_q <= estavel_d;
            subida_q  <= subida_d;
            descida_q <= descida_d;
            settle_q  <= settle_d;
            valido_q  <= valido_d;
        end
    end

    assign estavel = estavel_q;
    assign subida  = subida_q;
    assign descida = descida_q;
    assign valido  = valido_q;

endmodule
